sample_arbiter: RTL and testbench
=================================

SAMPLE_ARBITER -- requirements
Module: sample_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning width of one requester sample.
REQ-003 ID_W SHALL be ceil(log2(NUM_REQ)), minimum 1.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Port req_valid, input, NUM_REQ bits, SHALL carry per-requester sample-valid; bit i is requester i.
REQ-008 Port req_data, input, NUM_REQ*DATA_WIDTH bits, SHALL carry requester i's sample in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port req_ready, output, NUM_REQ bits, SHALL be per-requester accept, one-hot or zero.
REQ-010 Port pause, input, 1 bit, SHALL be the host request to stop accepting samples.
REQ-011 Port fifo_full, input, 1 bit, SHALL be the full flag from the downstream FIFO.
REQ-012 Port fifo_enqueue, output, 1 bit, SHALL be the enqueue strobe to the downstream FIFO.
REQ-013 Port fifo_back, output, BACK_W bits, SHALL be the FIFO write data (BACK_W per REQ-033).
REQ-014 Port paused, output, 1 bit, SHALL be high while the FSM is in PAUSED.
REQ-015 Port grant_id, output, ID_W bits, SHALL be the index of the requester granted this cycle; 0 when there is no grant.
REQ-016 Port stall_count, output, 32 bits, SHALL be the saturating count of stalled cycles.

Function
REQ-017 The grant SHALL be combinational: the first i with req_valid[i]=1, searching cyclically from rr_ptr upward (rr_ptr, rr_ptr+1, ... NUM_REQ-1, 0, ...).
REQ-018 commit SHALL be (grant exists) AND !fifo_full AND state==RUN AND !rst.
REQ-019 fifo_enqueue SHALL equal commit; req_ready[g] SHALL equal commit for granted g only; all other req_ready bits SHALL be 0; latency 0 cycles.
REQ-020 fifo_back SHALL be req_data of the granted requester when commit=1, else 0.
REQ-021 A sample SHALL transfer exactly when req_valid[i] AND req_ready[i]; the requester holds valid/data until then.
REQ-022 On commit, rr_ptr SHALL update to g+1, wrapping to 0 when g==NUM_REQ-1; rr_ptr SHALL otherwise hold.
REQ-023 fifo_full=1 SHALL block commit; fifo_enqueue SHALL never be asserted while fifo_full=1.
REQ-024 The FSM SHALL have states RUN and PAUSED: RUN->PAUSED on a cycle with pause=1; PAUSED->RUN on a cycle with pause=0; transitions are registered, so commit is still allowed in the cycle pause first rises.
REQ-025 In PAUSED, there SHALL be no commits and rr_ptr SHALL hold.
REQ-026 stall_count SHALL increment by 1 each cycle with state==RUN, |req_valid=1 and commit=0.
REQ-027 stall_count SHALL saturate at 32'hFFFF_FFFF and SHALL not increment in PAUSED.
REQ-028 When only one requester is valid, it SHALL be granted regardless of rr_ptr.
REQ-029 With all requesters continuously valid and the FIFO never full, grants SHALL cycle 0,1,...,NUM_REQ-1,0,...

Reset
REQ-030 While rst=1: req_ready=0, fifo_enqueue=0, fifo_back=0, grant_id=0.
REQ-031 rst=1 SHALL force the following values at the next edge: state RUN, paused=0, rr_ptr=0, stall_count=0.
REQ-032 Reset asserted mid-stream SHALL drop no accepted sample, since accepted samples are already enqueued; any pending request is re-arbitrated from rr_ptr=0.

Configuration
REQ-033 Macro SAMPLE_ARB_TAG_EN, when defined, SHALL set BACK_W=ID_W+DATA_WIDTH with fifo_back={grant_id, data}, ID in the MSBs.
REQ-034 When SAMPLE_ARB_TAG_EN is undefined, BACK_W SHALL equal DATA_WIDTH with fifo_back=data only; all other behaviour is identical.

Verification
REQ-035 Round-robin: NUM_REQ=4, req_valid=4'b1111 held, fifo_full=0 for 8 cycles -> grant_id 0,1,2,3,0,1,2,3; one fifo_enqueue per cycle.
REQ-036 Backpressure: req_valid=4'b0100, fifo_full=1 for 5 cycles then 0 -> no enqueue for 5 cycles, stall_count=5, then enqueue of requester 2 data on the 6th cycle.
REQ-037 Pause: pause=1 for cycles 3..6 with req_valid=4'b0001 -> commit in cycle 3, none in cycles 4..7 while paused=1, commits resume in cycle 8; stall_count unchanged during PAUSED.
REQ-038 Tag build: SAMPLE_ARB_TAG_EN defined, requester 3 sends 32'hDEADBEEF -> fifo_back=34'h3_DEADBEEF.
REQ-039 Reset mid-run: rst=1 for 1 cycle after grants 0,1 -> next grant with 4'b1111 is 0; stall_count=0.
REQ-040 Saturation: stall_count preloaded by force to 32'hFFFF_FFFE, 3 stalled cycles -> stall_count reads 32'hFFFF_FFFF.

Source files
------------

// File: rtl/sample_arbiter.sv
// sample_arbiter: round-robin arbiter that moves one requester sample per cycle
// into a downstream FIFO. It has a RUN/PAUSED host pause and keeps a saturating
// count of stalled cycles.
// Optional build macro SAMPLE_ARB_TAG_EN: when defined, the FIFO word carries
// the granted requester index in its MSBs above the sample data.
module sample_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  localparam int ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
`ifdef SAMPLE_ARB_TAG_EN
  localparam int BACK_W    = ID_W + DATA_WIDTH
`else
  localparam int BACK_W    = DATA_WIDTH
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          pause,
  input  logic                          fifo_full,
  output logic                          fifo_enqueue,
  output logic [BACK_W-1:0]             fifo_back,
  output logic                          paused,
  output logic [ID_W-1:0]               grant_id,
  output logic [31:0]                   stall_count
);

  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       cand;
  logic [ID_W-1:0]       gnt;
  logic                  found;
  logic                  commit;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic [31:0]           stall_q;

  // Saturating increment for the stall counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Cyclic priority search starting at rr_ptr; first valid requester wins.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  // Next-state logic for the host pause FSM; transitions take effect next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (pause)  state_d = PAUSED;
      PAUSED:  if (!pause) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register for the pause FSM.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Round-robin pointer moves past the winner only when a sample is accepted.
  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= '0;
    else if (commit) rr_ptr <= (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
  end

  // Stalled cycle: running, someone is waiting, nothing accepted.
  always_ff @(posedge clk) begin
    if (rst)                                    stall_q <= '0;
    else if (state_q == RUN && |req_valid && !commit) stall_q <= sat_inc(stall_q);
  end

  assign commit       = found && !fifo_full && (state_q == RUN) && !rst;
  assign gnt_data     = req_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
  assign fifo_enqueue = commit;
  assign req_ready    = commit ? (NUM_REQ'(1) << gnt) : '0;
  assign grant_id     = (found && !rst) ? gnt : '0;
  assign paused       = (state_q == PAUSED);
  assign stall_count  = stall_q;
`ifdef SAMPLE_ARB_TAG_EN
  assign fifo_back    = commit ? {gnt, gnt_data} : '0;
`else
  assign fifo_back    = commit ? gnt_data : '0;
`endif

endmodule

// File: tb/tb_sample_arbiter.sv
// tb_sample_arbiter: self-checking bench for sample_arbiter (NUM_REQ=4,
// DATA_WIDTH=32) with a queue-free behavioural reference model.
module tb_sample_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
`ifdef SAMPLE_ARB_TAG_EN
  localparam int BW = 2 + DW;
`else
  localparam int BW = DW;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            pause = 1'b0;
  logic            fifo_full = 1'b0;
  logic            fifo_enqueue;
  logic [BW-1:0]   fifo_back;
  logic            paused;
  logic [1:0]      grant_id;
  logic [31:0]     stall_count;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int     m_ptr = 0;
  bit     m_paused = 0;
  longint m_stall = 0;
  // reference model expectations for the current cycle
  bit            exp_found;
  int            exp_g;
  bit            exp_commit;
  logic [N-1:0]  exp_ready;
  logic [BW-1:0] exp_back;

  sample_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .pause(pause), .fifo_full(fifo_full),
    .fifo_enqueue(fifo_enqueue), .fifo_back(fifo_back), .paused(paused),
    .grant_id(grant_id), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom();
    return d;
  endfunction

  function automatic logic [BW-1:0] back_of(input int g, input logic [DW-1:0] d);
`ifdef SAMPLE_ARB_TAG_EN
    return {2'(g), d};
`else
    return BW'(g * 0) | d;
`endif
  endfunction

  function automatic void model_comb();
    exp_found = 0;
    exp_g     = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (!exp_found && req_valid[i]) begin
        exp_found = 1;
        exp_g     = i;
      end
    end
    exp_commit = exp_found && !fifo_full && !m_paused && !rst;
    exp_ready  = exp_commit ? N'(1 << exp_g) : '0;
    exp_back   = exp_commit ? back_of(exp_g, req_data[exp_g*DW +: DW]) : '0;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic full, input logic p,
                       input logic r, input logic [N*DW-1:0] d);
    @(negedge clk);
    req_valid = v;
    fifo_full = full;
    pause     = p;
    rst       = r;
    req_data  = d;
    #1;
    model_comb();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_paused = 0; m_stall = 0;
    end else begin
      if (!m_paused && (req_valid != 0) && !exp_commit)
        m_stall = (m_stall >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall + 1;
      if (exp_commit) m_ptr = (exp_g + 1) % N;
      m_paused = pause;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive('1, 0, 0, 1, rand_data());
      if (req_ready !== '0) begin $display("FAIL rst_ready got %h want 0", req_ready); miscompares++; end
      vectors++;
      if (fifo_enqueue !== 1'b0) begin $display("FAIL rst_enq got %b want 0", fifo_enqueue); miscompares++; end
      vectors++;
      if (fifo_back !== '0) begin $display("FAIL rst_back got %h want 0", fifo_back); miscompares++; end
      vectors++;
      if (grant_id !== '0) begin $display("FAIL rst_gid got %0d want 0", grant_id); miscompares++; end
      vectors++;
      tick();
    end
    drive('0, 0, 0, 0, rand_data());
    if (paused !== 1'b0) begin $display("FAIL rst_paused got %b want 0", paused); miscompares++; end
    vectors++;
    if (stall_count !== 32'd0) begin $display("FAIL rst_stall got %0d want 0", stall_count); miscompares++; end
    vectors++;
    tick();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 0, 0, 0, rand_data());
      if (grant_id !== 2'(i % N)) begin $display("FAIL rr_gid[%0d] got %0d want %0d", i, grant_id, i % N); miscompares++; end
      vectors++;
      if (fifo_enqueue !== 1'b1) begin $display("FAIL rr_enq[%0d] got %b want 1", i, fifo_enqueue); miscompares++; end
      vectors++;
      if (req_ready !== N'(1 << (i % N))) begin $display("FAIL rr_ready[%0d] got %b want %b", i, req_ready, N'(1 << (i % N))); miscompares++; end
      vectors++;
      if (fifo_back !== back_of(i % N, req_data[(i % N)*DW +: DW])) begin $display("FAIL rr_back[%0d] got %h", i, fifo_back); miscompares++; end
      vectors++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [N*DW-1:0] d;
    d = rand_data();
    drive('0, 0, 0, 1, d); tick();
    for (int c = 0; c < 5; c++) begin
      drive(4'b0100, 1, 0, 0, d);
      if (fifo_enqueue !== 1'b0) begin $display("FAIL bp_enq[%0d] got %b want 0", c, fifo_enqueue); miscompares++; end
      vectors++;
      if (req_ready !== '0) begin $display("FAIL bp_ready[%0d] got %b want 0", c, req_ready); miscompares++; end
      vectors++;
      tick();
    end
    drive(4'b0100, 0, 0, 0, d);
    if (stall_count !== 32'd5) begin $display("FAIL bp_stall got %0d want 5", stall_count); miscompares++; end
    vectors++;
    if (fifo_enqueue !== 1'b1 || req_ready !== 4'b0100) begin $display("FAIL bp_release got enq=%b ready=%b want 1/0100", fifo_enqueue, req_ready); miscompares++; end
    vectors++;
    if (fifo_back !== back_of(2, d[2*DW +: DW]) || grant_id !== 2'd2) begin $display("FAIL bp_back got %h gid %0d", fifo_back, grant_id); miscompares++; end
    vectors++;
    tick();
  endtask

  task automatic test_pause();
    drive('0, 0, 0, 1, rand_data()); tick();
    for (int c = 1; c <= 8; c++) begin
      bit p, e_enq, e_p;
      p     = (c >= 3 && c <= 6);
      e_enq = (c <= 3 || c == 8);
      e_p   = (c >= 4 && c <= 7);
      drive(4'b0001, 0, p, 0, rand_data());
      if (fifo_enqueue !== e_enq) begin $display("FAIL pause_enq[c%0d] got %b want %b", c, fifo_enqueue, e_enq); miscompares++; end
      vectors++;
      if (paused !== e_p) begin $display("FAIL pause_flag[c%0d] got %b want %b", c, paused, e_p); miscompares++; end
      vectors++;
      if (stall_count !== 32'd0) begin $display("FAIL pause_stall[c%0d] got %0d want 0", c, stall_count); miscompares++; end
      vectors++;
      tick();
    end
  endtask

  task automatic test_tag();
    logic [N*DW-1:0] d;
    logic [BW-1:0]   want;
    d = rand_data();
    d[3*DW +: DW] = 32'hDEADBEEF;
`ifdef SAMPLE_ARB_TAG_EN
    want = 34'h3_DEADBEEF;
`else
    want = 32'hDEADBEEF;
`endif
    drive(4'b1000, 0, 0, 0, d);
    if (fifo_back !== want) begin $display("FAIL tag_back got %h want %h", fifo_back, want); miscompares++; end
    vectors++;
    if (grant_id !== 2'd3) begin $display("FAIL tag_gid got %0d want 3", grant_id); miscompares++; end
    vectors++;
    tick();
  endtask

  task automatic test_reset_mid();
    drive('0, 0, 0, 1, rand_data()); tick();
    for (int i = 0; i < 2; i++) begin
      drive(4'b1111, 0, 0, 0, rand_data());
      if (grant_id !== 2'(i)) begin $display("FAIL rmid_gid[%0d] got %0d want %0d", i, grant_id, i); miscompares++; end
      vectors++;
      tick();
    end
    drive(4'b1111, 1, 0, 0, rand_data()); tick();
    drive(4'b1111, 0, 0, 1, rand_data()); tick();
    drive(4'b1111, 0, 0, 0, rand_data());
    if (grant_id !== 2'd0 || fifo_enqueue !== 1'b1) begin $display("FAIL rmid_regrant got gid %0d enq %b want 0/1", grant_id, fifo_enqueue); miscompares++; end
    vectors++;
    if (stall_count !== 32'd0) begin $display("FAIL rmid_stall got %0d want 0", stall_count); miscompares++; end
    vectors++;
    tick();
  endtask

  task automatic test_single();
    for (int i = 0; i < 12; i++) begin
      int j;
      j = $urandom_range(N - 1);
      drive(N'(1 << j), 0, 0, 0, rand_data());
      if (grant_id !== 2'(j) || req_ready !== N'(1 << j)) begin $display("FAIL single[%0d] got gid %0d ready %b want %0d", i, grant_id, req_ready, j); miscompares++; end
      vectors++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(N'($urandom()), ($urandom_range(2) == 0), ($urandom_range(4) == 0),
            ($urandom_range(24) == 0), rand_data());
      if (fifo_enqueue !== exp_commit) begin $display("FAIL rnd_enq[%0d] got %b want %b", i, fifo_enqueue, exp_commit); miscompares++; end
      vectors++;
      if (fifo_enqueue && fifo_full) begin $display("FAIL rnd_full_enq[%0d] got enq=1 want 0", i); miscompares++; end
      vectors++;
      if (req_ready !== exp_ready) begin $display("FAIL rnd_ready[%0d] got %b want %b", i, req_ready, exp_ready); miscompares++; end
      vectors++;
      if (fifo_back !== exp_back) begin $display("FAIL rnd_back[%0d] got %h want %h", i, fifo_back, exp_back); miscompares++; end
      vectors++;
      if (exp_commit && grant_id !== 2'(exp_g)) begin $display("FAIL rnd_gid[%0d] got %0d want %0d", i, grant_id, exp_g); miscompares++; end
      vectors++;
      if (paused !== m_paused) begin $display("FAIL rnd_paused[%0d] got %b want %b", i, paused, m_paused); miscompares++; end
      vectors++;
      if (stall_count !== 32'(m_stall)) begin $display("FAIL rnd_stall[%0d] got %0d want %0d", i, stall_count, m_stall); miscompares++; end
      vectors++;
      tick();
    end
  endtask

  task automatic test_saturation();
    drive('0, 0, 0, 1, rand_data()); tick();
    drive(4'b0001, 1, 0, 0, rand_data());
    force dut.stall_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_q;
    m_stall = 64'hFFFF_FFFE;
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0001, 1, 0, 0, rand_data());
      if (stall_count !== 32'hFFFF_FFFF) begin $display("FAIL sat_stall[%0d] got %h want ffffffff", c, stall_count); miscompares++; end
      vectors++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_pause();
    test_tag();
    test_reset_mid();
    test_single();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
